// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and frame constants for the boot loader.
//   state_t        - loader FSM states
//   HDR_LEN        - number of length bytes at the head of a frame
//   BYTES_PER_WORD - bytes assembled into each 32-bit RAM word
package prog_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    CSUM   = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int HDR_LEN        = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/ld_word_assembler.sv
// ld_word_assembler: packs bytes MSB-first into a 32-bit word.
//   clk, rst    - clock, synchronous active-high reset
//   clear       - restart byte counting at the first byte of a word
//   byte_valid  - a data byte is being accepted this cycle
//   byte_data   - the byte
//   word        - shift register contents (complete the cycle after word_valid)
//   word_valid  - the accepted byte is the 4th of a word
module ld_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] byte_cnt;

  // The counter wraps 3 -> 0 naturally, so consecutive words need no clear.
  assign word_valid = byte_valid && (byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      word     <= 32'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      word     <= {word[23:0], byte_data};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time loader between a byte stream and the CPU/RAM pair.
// Receives LEN_HI, LEN_LO, 4*N data bytes (MSB first per word), CSUM, writes
// words to RAM from address 0 with the CPU held in reset, then hands the RAM
// port to the CPU on a good checksum. Errors hold the CPU in reset until rst.
//   rx_valid/rx_data/rx_ready - byte stream input
//   cpu_wrEn/cpu_addr/cpu_wdata - CPU RAM port, passed through in RUN
//   ram_we/ram_addr/ram_wdata - RAM write port
//   cpu_rst, done, error - status (registered)
//   dbg_state - current FSM state
// Handshake: a byte transfers on a posedge where rx_valid && rx_ready; the
// producer holds rx_data stable while rx_valid is high and not yet accepted.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int SIZE  = 10,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            rx_ready,
  input  logic            cpu_wrEn,
  input  logic [SIZE-1:0] cpu_addr,
  input  logic [31:0]     cpu_wdata,
  output logic            ram_we,
  output logic [SIZE-1:0] ram_addr,
  output logic [31:0]     ram_wdata,
  output logic            cpu_rst,
  output logic            done,
  output logic            error,
  output state_t          dbg_state
);

  state_t        state, state_next;
  logic [7:0]    len_hi;
  logic [15:0]   len;
  logic [15:0]   len_in;
  logic [SIZE:0] idx;      // one extra bit so N == DEPTH is representable
  logic [7:0]    csum;
  logic          accept;
  logic          last_word;
  logic [31:0]   word;
  logic          word_valid;

  assign dbg_state = state;
  assign accept    = rx_valid && rx_ready;
  assign len_in    = {len_hi, rx_data};
  assign last_word = (17'(idx) + 17'd1) == 17'(len);

  ld_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == LEN_LO && accept),
    .byte_valid (state == DATA && accept),
    .byte_data  (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = 32'd0;
    case (state)
      LEN_HI: begin
        rx_ready = 1'b1;
        if (accept) state_next = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (accept) begin
          if (32'(len_in) > 32'(DEPTH)) state_next = ERR;
          else if (len_in == 16'd0)     state_next = CSUM;
          else                          state_next = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (word_valid) state_next = WRITE;
      end
      WRITE: begin
        ram_we     = 1'b1;
        ram_addr   = idx[SIZE-1:0];
        ram_wdata  = word;
        state_next = last_word ? CSUM : DATA;
      end
      CSUM: begin
        rx_ready = 1'b1;
        if (accept) state_next = (rx_data == csum) ? RUN : ERR;
      end
      RUN: begin
        ram_we    = cpu_wrEn;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      default: ;  // ERR: everything quiet
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LEN_HI;
      len_hi  <= 8'd0;
      len     <= 16'd0;
      idx     <= '0;
      csum    <= 8'd0;
      cpu_rst <= 1'b1;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state <= state_next;
      // Checksum covers length and data bytes, never the CSUM byte itself.
      if (accept && state != CSUM) csum <= csum ^ rx_data;
      if (accept && state == LEN_HI) len_hi <= rx_data;
      if (accept && state == LEN_LO) begin
        len <= len_in;
        idx <= '0;
      end
      if (state == WRITE) idx <= idx + 1'b1;
      // Status decoded from the next state so it flips with the state edge.
      cpu_rst <= (state_next != RUN);
      done    <= (state_next == RUN);
      error   <= (state_next == ERR);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int SIZE = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'd0;
  logic            rx_ready;
  logic            cpu_wrEn = 1'b0;
  logic [SIZE-1:0] cpu_addr = '0;
  logic [31:0]     cpu_wdata = 32'd0;
  logic            ram_we;
  logic [SIZE-1:0] ram_addr;
  logic [31:0]     ram_wdata;
  logic            cpu_rst, done, error;
  state_t          dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_bad   = 0;   // load cycles where rx_ready != !ram_we

  logic [SIZE-1:0] wr_addr_q[$];
  logic [31:0]     wr_data_q[$];
  logic [31:0]     exp_q[$];

  prog_loader #(.SIZE(SIZE), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .cpu_rst(cpu_rst), .done(done), .error(error),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log RAM writes and the loading-phase handshake rule.
  always @(negedge clk) begin
    if (ram_we) begin
      wr_addr_q.push_back(ram_addr);
      wr_data_q.push_back(ram_wdata);
    end
    if (!rst && !done && !error && (rx_ready !== !ram_we)) hs_bad++;
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    hs_bad = 0;
  endtask

  // Present one byte after 'gap' idle cycles; waits (bounded) for acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = rx_ready;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] f[], input bit gaps);
    foreach (f[i]) send_byte(f[i], gaps ? int'($urandom_range(1, 5)) : 0);
  endtask

  // Scoreboard: compare logged writes against exp_q in address order.
  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wr_data_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < wr_data_q.size()) begin
        chk({tag, "_addr"}, 32'(wr_addr_q[i]), i);
        chk({tag, "_data"}, wr_data_q[i], exp_q[i]);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] good[] = '{8'h00, 8'h02, 8'h20, 8'h11, 8'h40, 8'h45,
                         8'h10, 8'h11, 8'h40, 8'h01, 8'h76};
  logic [7:0] bad[]  = '{8'h00, 8'h02, 8'h20, 8'h11, 8'h40, 8'h45,
                         8'h10, 8'h11, 8'h40, 8'h01, 8'h77};
  logic [7:0] big[]  = '{8'h04, 8'h01};
  logic [7:0] empty_ok[]  = '{8'h00, 8'h00, 8'h00};
  logic [7:0] empty_bad[] = '{8'h00, 8'h00, 8'h01};
  logic [7:0] partial[]   = '{8'h00, 8'h02, 8'h20, 8'h11};
  int t0;

  initial begin
    exp_q = '{32'h20114045, 32'h10114001};

    // Reset state
    do_reset();
    chk("rst_state", 32'(dbg_state), 32'(LEN_HI));
    chk("rst_ready", 32'(rx_ready), 32'd1);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);

    // Scenario 1: full-rate good frame, 2 + 5*2 + 1 = 13 cycles to RUN
    t0 = cyc;
    send_frame(good, 1'b0);
    chk("s1_cycles", 32'(cyc - t0), 32'd13);
    chk("s1_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_error", 32'(error), 32'd0);
    chk("s1_ready", 32'(rx_ready), 32'd0);
    chk("s1_hs", 32'(hs_bad), 32'd0);
    check_writes("s1");

    // Scenario 2: bad checksum
    do_reset();
    send_frame(bad, 1'b0);
    chk("s2_error", 32'(error), 32'd1);
    chk("s2_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("s2_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("s2_ready", 32'(rx_ready), 32'd0);
    chk("s2_we", 32'(ram_we), 32'd0);

    // Scenario 3: oversize length 1025
    do_reset();
    send_frame(big, 1'b0);
    chk("s3_error", 32'(error), 32'd1);
    chk("s3_nwr", 32'(wr_data_q.size()), 32'd0);
    chk("s3_ready", 32'(rx_ready), 32'd0);

    // Scenario 4: empty frames
    do_reset();
    send_frame(empty_ok, 1'b0);
    chk("s4_done", 32'(done), 32'd1);
    chk("s4_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("s4_nwr", 32'(wr_data_q.size()), 32'd0);
    do_reset();
    send_frame(empty_bad, 1'b0);
    chk("s4b_error", 32'(error), 32'd1);
    chk("s4b_done", 32'(done), 32'd0);

    // Scenario 5: good frame with random rx_valid gaps
    do_reset();
    send_frame(good, 1'b1);
    chk("s5_done", 32'(done), 32'd1);
    chk("s5_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("s5_hs", 32'(hs_bad), 32'd0);
    check_writes("s5");

    // Scenario 6: reset mid-DATA, then reload; then CPU pass-through
    do_reset();
    send_frame(partial, 1'b0);
    chk("s6_mid_state", 32'(dbg_state), 32'(DATA));
    do_reset();
    chk("s6_rst_state", 32'(dbg_state), 32'(LEN_HI));
    chk("s6_rst_cpu", 32'(cpu_rst), 32'd1);
    send_frame(good, 1'b0);
    chk("s6_done", 32'(done), 32'd1);
    check_writes("s6");
    cpu_wrEn = 1'b1; cpu_addr = 10'd69; cpu_wdata = 32'd5;
    #1;
    chk("s6_pt_we", 32'(ram_we), 32'd1);
    chk("s6_pt_addr", 32'(ram_addr), 32'd69);
    chk("s6_pt_wdata", ram_wdata, 32'd5);
    cpu_wrEn = 1'b0; cpu_addr = '0; cpu_wdata = 32'd0;

    // Reset while in RUN returns the CPU to reset
    do_reset();
    chk("s7_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("s7_done", 32'(done), 32'd0);
    chk("s7_we", 32'(ram_we), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the CPU/RAM pair. It receives a framed byte stream (length, big-endian 32-bit words, XOR checksum) and writes the words into the block RAM starting at address 0, holding the CPU in reset throughout. On a valid checksum it hands the RAM port to the CPU and releases CPU reset. On an error it holds the CPU in reset until `rst`.

## Interface
Parameters:
- SIZE, 10: RAM address width.
- DEPTH, 1024: RAM depth in words; largest legal word count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rx_valid  in  1  byte-stream valid.
- rx_data  in  8  byte-stream data.
- rx_ready  out  1  loader accepts a byte this cycle.
- cpu_wrEn  in  1  CPU write enable, passed through in RUN.
- cpu_addr  in  SIZE  CPU address, passed through in RUN.
- cpu_wdata  in  32  CPU write data, passed through in RUN.
- ram_we  out  1  RAM write enable.
- ram_addr  out  SIZE  RAM address.
- ram_wdata  out  32  RAM write data.
- cpu_rst  out  1  reset to CPU, active-high.
- done  out  1  load completed with good checksum.
- error  out  1  load aborted (oversize length or checksum mismatch).

## Operation
- A byte is accepted on a posedge with rx_valid && rx_ready. Bytes are ignored while rx_ready=0.
- Frame format: LEN_HI, LEN_LO (16-bit word count N), then 4·N data bytes, MSB first per word, then CSUM.
- CSUM must equal the XOR of all preceding frame bytes (length and data).
- States:
  - LEN_HI: rx_ready=1. Accept byte → LEN_LO.
  - LEN_LO: rx_ready=1. Accept byte. If N > DEPTH → ERR. If N=0 → CSUM. Otherwise → DATA with index=0 and byte count=0.
  - DATA: rx_ready=1. Shift each byte into a 32-bit word register. The 4th byte → WRITE.
  - WRITE: rx_ready=0, ram_we=1, ram_addr=index, ram_wdata=assembled word, index+1. If index+1 == N → CSUM, else → DATA.
  - CSUM: rx_ready=1. On accept, match → RUN, mismatch → ERR.
  - RUN: rx_ready=0. ram_we/ram_addr/ram_wdata = cpu_wrEn/cpu_addr/cpu_wdata combinationally. cpu_rst=0, done=1. Terminal until rst.
  - ERR: rx_ready=0, ram_we=0, cpu_rst=1, error=1. Terminal until rst.
- Running checksum register is XOR-accumulated on every accepted byte except CSUM itself.
- Index counter is SIZE+1 bits so that N=DEPTH is representable. The last written address is N-1.

## Timing
- Reset values (cycle after rst sampled high): state=LEN_HI, rx_ready=1, ram_we=0, ram_addr=0, ram_wdata=0, cpu_rst=1, done=0, error=0, checksum=0, index=0.
- Reset during any state (including RUN) aborts immediately. cpu_rst goes high and RAM contents are not cleared.
- Outside RUN and WRITE, ram_we=0, ram_addr=0, ram_wdata=0.
- Each word costs at least 5 cycles: 4 accept cycles plus 1 WRITE cycle. Full-rate stream of N words takes 2 + 5N + 1 cycles to RUN.
- cpu_rst falls and done rises in the cycle after the CSUM byte is accepted. Both are registered-state-derived and glitch-free.
- The CPU's first fetch happens after the last RAM write. No write/fetch overlap is possible.
- rx_valid stalls (gaps) in any receiving state hold all state and counters unchanged.

## Structure
- Package `prog_loader_pkg` holds:
  - the state enum (LEN_HI, LEN_LO, DATA, WRITE, CSUM, RUN, ERR);
  - frame constants (header length 2, bytes per word 4).
- One natural sub-module, `ld_word_assembler`: shift register plus 2-bit byte counter, emitting `word_valid` on the 4th byte.
- The top module holds the FSM, index counter, checksum, and RAM-port mux.

## Test plan
- Bytes 00 02 20 11 40 45 10 11 40 01 76 → writes addr0=32'h20114045, addr1=32'h10114001, then cpu_rst=0 and done=1.
- Same frame with CSUM=77 → no change to cpu_rst, error=1 after CSUM, rx_ready=0 thereafter.
- Length 04 01 (1025) → error=1 the cycle after LEN_LO, no ram_we pulses.
- Bytes 00 00 00 → no RAM writes, done=1. A second frame 00 00 01 → error=1.
- Frame from scenario 1 with random rx_valid gaps (1-5 cycles) → identical writes and final state. rx_ready=0 exactly in WRITE cycles.
- rst pulsed mid-DATA, then scenario 1 frame resent → correct load. In RUN, cpu_wrEn=1, cpu_addr=69, cpu_wdata=5 → ram_we=1, ram_addr=69, ram_wdata=5 same cycle.
